// File: rtl/jtkicker_sdram_rsp.sv
// SDRAM-side responder: turns ROM read requests into BURST single-word
// back-end reads, and download writes into single back-end writes.
// Every back-end word is bounded by MAXWAIT cycles. A word that runs out of
// time completes with data 0000 and raises the sticky timeout flag.
module jtkicker_sdram_rsp #(
  parameter int BURST   = 2,
  parameter int AW      = 22,
  parameter int MAXWAIT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          sdram_req,
  input  logic [AW-1:0] sdram_addr,
  output logic          sdram_ack,
  output logic          data_dst,
  output logic          data_rdy,
  output logic [15:0]   data_read,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_mask,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ok,
  output logic          timeout
);

  localparam int WCW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     din_q, din_d;
  logic [1:0]      mask_q, mask_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            ack_q, ack_d;
  logic            dst_q, dst_d;
  logic            rdy_q, rdy_d;
  logic [15:0]     data_q, data_d;
  logic [7:0]      wait_q, wait_d;
  logic [WCW-1:0]  word_q, word_d;
  logic            timeout_q, timeout_d;

  // The wait budget is spent once MAXWAIT cycles have passed without mem_ok.
  logic expired;
  logic done;
  logic last_word;

  assign expired   = (wait_q == 8'(MAXWAIT - 1)) && !mem_ok;
  assign done      = mem_ok || expired;
  assign last_word = (word_q == WCW'(BURST - 1));

  // Next-state and output decode. Requests are only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    mask_d    = mask_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    ack_d     = 1'b0;
    dst_d     = 1'b0;
    rdy_d     = 1'b0;
    data_d    = data_q;
    wait_d    = wait_q;
    word_d    = word_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (downloading) begin
          if (prog_we) begin
            addr_d  = prog_addr;
            din_d   = prog_data;
            mask_d  = prog_mask;
            wr_d    = 1'b1;
            wait_d  = 8'd0;
            state_d = ST_WR;
          end
        end else if (sdram_req) begin
          ack_d   = 1'b1;
          addr_d  = sdram_addr;
          word_d  = '0;
          wait_d  = 8'd0;
          rd_d    = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (done) begin
          data_d = mem_ok ? mem_dout : 16'h0000;
          if (!mem_ok) timeout_d = 1'b1;
          dst_d  = (word_q == '0);
          rdy_d  = last_word;
          wait_d = 8'd0;
          if (last_word) begin
            rd_d    = 1'b0;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
            word_d = word_q + 1'b1;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WR: begin
        if (done) begin
          if (!mem_ok) timeout_d = 1'b1;
          wr_d    = 1'b0;
          ack_d   = 1'b1;
          wait_d  = 8'd0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any access in flight without pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      mask_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ack_q     <= 1'b0;
      dst_q     <= 1'b0;
      rdy_q     <= 1'b0;
      data_q    <= '0;
      wait_q    <= '0;
      word_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      mask_q    <= mask_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ack_q     <= ack_d;
      dst_q     <= dst_d;
      rdy_q     <= rdy_d;
      data_q    <= data_d;
      wait_q    <= wait_d;
      word_q    <= word_d;
      timeout_q <= timeout_d;
    end
  end

  assign sdram_ack = ack_q;
  assign data_dst  = dst_q;
  assign data_rdy  = rdy_q;
  assign data_read = data_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign mem_mask  = mask_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_jtkicker_sdram_rsp.sv
// Bench for jtkicker_sdram_rsp: a behavioural back-end memory with a
// programmable latency, plus directed and random read/write transactions.
// Expected timing and data come from the transaction-level rules.
module tb_jtkicker_sdram_rsp;

  localparam int AW    = 22;
  localparam int BURST = 2;
  localparam int MAXW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          downloading;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          data_dst;
  logic          data_rdy;
  logic [15:0]   data_read;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_mask;
  logic [15:0]   mem_dout;
  logic          mem_ok;
  logic          timeout;

  jtkicker_sdram_rsp #(.BURST(BURST), .AW(AW), .MAXWAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_mask(mem_mask),
    .mem_dout(mem_dout), .mem_ok(mem_ok), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Back-end memory: written words are stored, others follow a fixed pattern.
  logic [15:0] mem [int unsigned];

  function automatic logic [15:0] mem_read(input logic [AW-1:0] a);
    int unsigned k;
    k = a;
    if (mem.exists(k)) return mem[k];
    return 16'(k) ^ 16'h5A3C ^ 16'(k >> 6);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] m);
    logic [15:0] r;
    r[15:8] = m[1] ? old[15:8] : d[15:8];
    r[7:0]  = m[0] ? old[7:0]  : d[7:0];
    return r;
  endfunction

  // Back-end responder: answers each word after be_lat cycles of strobe.
  int            be_lat = 1;
  bit            never = 1'b0;
  int            be_cnt = 0;
  int unsigned   be_key;
  logic [15:0]   be_old;
  logic [AW-1:0] addr_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [15:0]   wr_din_log[$];
  logic [1:0]    wr_mask_log[$];

  always @(negedge clk) begin
    if (rst || never || !(mem_rd || mem_wr)) begin
      be_cnt = 0;
      mem_ok = 1'b0;
    end else begin
      be_cnt++;
      if (be_cnt >= be_lat) begin
        be_cnt = 0;
        mem_ok = 1'b1;
        if (mem_rd) begin
          mem_dout = mem_read(mem_addr);
          addr_log.push_back(mem_addr);
        end else begin
          be_key = mem_addr;
          be_old = mem_read(mem_addr);
          mem[be_key] = merge(be_old, mem_din, mem_mask);
          wr_addr_log.push_back(mem_addr);
          wr_din_log.push_back(mem_din);
          wr_mask_log.push_back(mem_mask);
          mem_dout = 16'hxxxx;
        end
      end else begin
        mem_ok = 1'b0;
      end
    end
  end

  // Read transaction: nreq bursts with sdram_req held until the nreq-th ack.
  task automatic run_read(input logic [AW-1:0] a, input int lat, input int nreq);
    int le, t0, win, base;
    int n_ack, n_dst, n_rdy;
    int ack_c[4], dst_c[4], rdy_c[4];
    logic [15:0] dst_v[4], rdy_v[4];
    logic [15:0] w0, w1;
    logic [AW-1:0] a1;
    le = never ? MAXW : lat;
    a1 = a + 22'd1;
    w0 = never ? 16'h0000 : mem_read(a);
    w1 = never ? 16'h0000 : mem_read(a1);
    for (int i = 0; i < 4; i++) begin
      ack_c[i] = -1; dst_c[i] = -1; rdy_c[i] = -1;
      dst_v[i] = 16'hxxxx; rdy_v[i] = 16'hxxxx;
    end
    n_ack = 0; n_dst = 0; n_rdy = 0;
    addr_log.delete();
    be_lat = lat;
    downloading = 1'b0;
    sdram_addr = a;
    sdram_req = 1'b1;
    t0 = cyc;
    win = 1 + (nreq - 1) * (2 * le + 1) + 2 * le + 4;
    for (int c = 0; c < win; c++) begin
      @(negedge clk);
      if (sdram_ack) begin
        if (n_ack < 4) ack_c[n_ack] = cyc;
        n_ack++;
        if (n_ack >= nreq) sdram_req = 1'b0;
      end
      if (data_dst) begin
        if (n_dst < 4) begin dst_c[n_dst] = cyc; dst_v[n_dst] = data_read; end
        n_dst++;
      end
      if (data_rdy) begin
        if (n_rdy < 4) begin rdy_c[n_rdy] = cyc; rdy_v[n_rdy] = data_read; end
        n_rdy++;
      end
    end
    sdram_req = 1'b0;
    chk("rd_ack_cnt", n_ack, nreq);
    chk("rd_dst_cnt", n_dst, nreq);
    chk("rd_rdy_cnt", n_rdy, nreq);
    for (int i = 0; i < nreq; i++) begin
      base = t0 + 1 + i * (2 * le + 1);
      chk("rd_ack_cyc", ack_c[i], base);
      chk("rd_dst_cyc", dst_c[i], base + le);
      chk("rd_dst_data", {16'h0, dst_v[i]}, {16'h0, w0});
      chk("rd_rdy_cyc", rdy_c[i], base + 2 * le);
      chk("rd_rdy_data", {16'h0, rdy_v[i]}, {16'h0, w1});
    end
    chk("rd_addr_cnt", addr_log.size(), never ? 0 : 2 * nreq);
    for (int i = 0; i < addr_log.size(); i++)
      chk("rd_mem_addr", {10'h0, addr_log[i]}, {10'h0, (i % 2) ? a1 : a});
    chk("rd_hold", {16'h0, data_read}, {16'h0, w1});
    $display("read  addr=%06h lat=%0d bursts=%0d acks=%0d dst=%04h rdy=%04h timeout=%0b",
             a, le, nreq, n_ack, dst_v[0], rdy_v[0], timeout);
  endtask

  // Download write, optionally with a read request held alongside it.
  task automatic run_write(input logic [AW-1:0] a, input logic [15:0] d,
                           input logic [1:0] m, input int lat, input bit with_req);
    int t0, n_ack, ack_c;
    logic [15:0] expn;
    expn = merge(mem_read(a), d, m);
    wr_addr_log.delete(); wr_din_log.delete(); wr_mask_log.delete();
    n_ack = 0; ack_c = -1;
    be_lat = lat;
    downloading = 1'b1;
    prog_addr = a; prog_data = d; prog_mask = m; prog_we = 1'b1;
    sdram_addr = 22'($urandom);
    sdram_req = with_req;
    t0 = cyc;
    for (int c = 0; c < lat + 6; c++) begin
      @(negedge clk);
      if (sdram_ack) begin
        n_ack++;
        ack_c = cyc;
        prog_we = 1'b0;
      end
    end
    prog_we = 1'b0;
    sdram_req = 1'b0;
    downloading = 1'b0;
    chk("wr_ack_cnt", n_ack, 1);
    chk("wr_ack_cyc", ack_c, t0 + lat + 1);
    chk("wr_cnt", wr_addr_log.size(), 1);
    if (wr_addr_log.size() > 0) begin
      chk("wr_addr", {10'h0, wr_addr_log[0]}, {10'h0, a});
      chk("wr_din", {16'h0, wr_din_log[0]}, {16'h0, d});
      chk("wr_mask", {30'h0, wr_mask_log[0]}, {30'h0, m});
    end
    chk("wr_merge", {16'h0, mem_read(a)}, {16'h0, expn});
    $display("write addr=%06h data=%04h mask=%02b lat=%0d req=%0b acks=%0d",
             a, d, m, lat, with_req, n_ack);
  endtask

  initial begin
    int n_pulse;
    bit seen;
    logic [AW-1:0] ra;
    mem[32'h1234] = 16'hABCD;
    mem[32'h1235] = 16'hEF01;
    rst = 1'b1; downloading = 1'b0; sdram_req = 1'b0; sdram_addr = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_mask = '0;
    mem_dout = '0; mem_ok = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", sdram_ack, 0);
    chk("rst_dst_rdy", {data_dst, data_rdy}, 0);
    chk("rst_data", data_read, 0);
    chk("rst_strobes", {mem_rd, mem_wr}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    run_read(22'h001234, 3, 1);
    run_write(22'h000010, 16'h5AA5, 2'b01, 2, 1'b1);
    run_read(22'h3FFFFF, 2, 1);
    run_read(22'h001234, 1, 2);

    chk("to_before", timeout, 0);
    never = 1'b1;
    run_read(22'h000100, 1, 1);
    chk("to_set", timeout, 1);
    never = 1'b0;
    run_read(22'h000200, 2, 1);
    chk("to_sticky", timeout, 1);

    // Reset in the middle of a burst, right after word 0.
    be_lat = 3;
    sdram_addr = 22'h000040;
    sdram_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (sdram_ack) sdram_req = 1'b0;
      if (data_dst) seen = 1'b1;
    end
    sdram_req = 1'b0;
    chk("rstmid_dst_seen", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_mem_rd", mem_rd, 0);
    rst = 1'b0;
    n_pulse = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (data_rdy || sdram_ack || data_dst) n_pulse++;
    end
    chk("rstmid_no_pulse", n_pulse, 0);
    chk("rstmid_timeout", timeout, 0);
    $display("reset mid-burst addr=000040 pulses_after=%0d", n_pulse);
    run_read(22'h000020, 2, 1);

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0, 1: begin
          ra = ($urandom_range(0, 3) == 0) ? 22'h3FFFFF : 22'($urandom);
          run_read(ra, $urandom_range(1, MAXW), $urandom_range(1, 2));
        end
        default: begin
          ra = 22'($urandom_range(0, 63));
          run_write(ra, 16'($urandom), 2'($urandom), $urandom_range(1, 4),
                    1'($urandom));
          run_read(ra, $urandom_range(1, 4), 1);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
    $fatal(1, "watchdog");
  end

endmodule
